// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave: controller states, field lengths and command opcodes.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA_RX,
    ST_DATA_TX,
    ST_WAIT_CS
  } ctrl_state_e;

  localparam logic [5:0] LEN_CMD  = 6'd8;
  localparam logic [5:0] LEN_REG  = 6'd8;
  localparam logic [5:0] LEN_ADDR = 6'd32;
  localparam logic [5:0] LEN_DATA = 6'd32;

  localparam logic [7:0] CMD_WR_REG0    = 8'h01;
  localparam logic [7:0] CMD_WR_MEM     = 8'h02;
  localparam logic [7:0] CMD_RD_REG0    = 8'h05;
  localparam logic [7:0] CMD_RD_REG1    = 8'h07;
  localparam logic [7:0] CMD_RD_MEM_FST = 8'h0B;
  localparam logic [7:0] CMD_WR_REG1    = 8'h11;

endpackage

// File: rtl/spi_slave_dummy_cnt.sv
// Loadable 8-bit down-counter for the dummy phase; load wins over decrement and the count
// saturates at zero, which o_zero reports.
module spi_slave_dummy_cnt (
  input  logic       sclk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/spi_slave_ctrl_fsm.sv
// SPI slave transaction sequencer: latches the command, walks addr/dummy/data phases from the
// decoder flags, programs shifter lengths and issues memory/register strobes (all registered).
module spi_slave_ctrl_fsm
  import spi_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [7:0]        cmd,
  input  logic              get_addr,
  input  logic              get_data,
  input  logic              send_data,
  input  logic              enable_cont,
  input  logic              enable_regs,
  input  logic              wait_dummy,
  input  logic              error,
  input  logic [1:0]        reg_sel,
  input  logic [7:0]        dummy_cycles,
  output logic [5:0]        rx_len,
  output logic              rx_len_upd,
  output logic [5:0]        tx_len,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              rd_req,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  output logic              reg_wr_en,
  output logic [1:0]        reg_addr,
  output logic              err_flag
);

  ctrl_state_e       r_state, w_state_nxt;
  logic [7:0]        r_cmd, w_cmd_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic [1:0]        r_reg_addr, w_reg_addr_nxt;
  logic [5:0]        r_rx_len, w_rx_len_nxt, r_tx_len, w_tx_len_nxt;
  logic              r_err_flag, w_err_nxt, r_tx_pend, w_tx_pend_nxt;
  logic              r_rx_len_upd, w_rx_len_upd_nxt, r_tx_start, w_tx_start_nxt;
  logic              r_addr_valid, w_addr_valid_nxt, r_rd_req, w_rd_req_nxt;
  logic              r_wr_valid, w_wr_valid_nxt, r_reg_wr_en, w_reg_wr_en_nxt;
  logic              w_cnt_load, w_cnt_dec, w_cnt_zero;

  spi_slave_dummy_cnt u_dummy_cnt (
    .sclk       (sclk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (dummy_cycles),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge sclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_nxt        = r_cmd;
    w_addr_nxt       = r_addr;
    w_wr_data_nxt    = r_wr_data;
    w_reg_addr_nxt   = r_reg_addr;
    w_rx_len_nxt     = r_rx_len;
    w_tx_len_nxt     = r_tx_len;
    w_err_nxt        = r_err_flag;
    w_tx_pend_nxt    = 1'b0;
    w_rx_len_upd_nxt = 1'b0;
    w_tx_start_nxt   = 1'b0;
    w_addr_valid_nxt = 1'b0;
    w_rd_req_nxt     = 1'b0;
    w_wr_valid_nxt   = 1'b0;
    w_reg_wr_en_nxt  = 1'b0;
    w_cnt_load       = 1'b0;
    w_cnt_dec        = 1'b0;
    // Chip-select release overrides every phase action in the same cycle.
    if (cs_n) begin
      w_err_nxt = 1'b0;
      if (r_state != ST_IDLE) begin
        w_state_nxt      = ST_IDLE;
        w_rx_len_nxt     = LEN_CMD;
        w_rx_len_upd_nxt = 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_rx_len_nxt = LEN_CMD;
          if (rx_valid) begin
            w_cmd_nxt   = rx_data[7:0];
            w_state_nxt = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (error) begin
            w_state_nxt = ST_WAIT_CS;
            w_err_nxt   = 1'b1;
          end else if (get_addr) begin
            w_state_nxt      = ST_ADDR;
            w_rx_len_nxt     = LEN_ADDR;
            w_rx_len_upd_nxt = 1'b1;
          end else if (get_data) begin
            w_state_nxt      = ST_DATA_RX;
            w_rx_len_nxt     = LEN_REG;
            w_rx_len_upd_nxt = 1'b1;
            w_reg_addr_nxt   = reg_sel;
          end else if (send_data) begin
            w_state_nxt    = ST_DATA_TX;
            w_tx_len_nxt   = LEN_REG;
            w_tx_start_nxt = 1'b1;
            w_reg_addr_nxt = reg_sel;
          end else begin
            w_state_nxt = ST_WAIT_CS;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            w_addr_nxt       = ADDR_W'(rx_data);
            w_addr_valid_nxt = 1'b1;
            if (wait_dummy) begin
              w_state_nxt  = ST_DUMMY;
              w_rd_req_nxt = 1'b1;
              w_cnt_load   = 1'b1;
            end else begin
              w_state_nxt      = ST_DATA_RX;
              w_rx_len_nxt     = LEN_DATA;
              w_rx_len_upd_nxt = 1'b1;
            end
          end
        end
        ST_DUMMY: begin
          if (w_cnt_zero) begin
            w_state_nxt    = ST_DATA_TX;
            w_tx_len_nxt   = LEN_DATA;
            w_tx_start_nxt = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ST_DATA_RX: begin
          // Burst writes advance the address once the write pulse has been seen downstream.
          if (r_wr_valid && enable_cont) w_addr_nxt = r_addr + ADDR_W'(4);
          if (rx_valid) begin
            w_wr_data_nxt = rx_data;
            if (enable_regs) w_reg_wr_en_nxt = 1'b1;
            else             w_wr_valid_nxt  = 1'b1;
            if (!enable_cont) w_state_nxt = ST_WAIT_CS;
          end
        end
        ST_DATA_TX: begin
          if (r_tx_pend) begin
            w_tx_start_nxt = 1'b1;
          end else if (tx_done) begin
            if (enable_cont) begin
              w_addr_nxt    = r_addr + ADDR_W'(4);
              w_rd_req_nxt  = 1'b1;
              w_tx_pend_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_WAIT_CS;
            end
          end
        end
        ST_WAIT_CS: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_cmd        <= 8'd0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_reg_addr   <= 2'd0;
      r_rx_len     <= LEN_CMD;
      r_tx_len     <= LEN_REG;
      r_err_flag   <= 1'b0;
      r_tx_pend    <= 1'b0;
      r_rx_len_upd <= 1'b0;
      r_tx_start   <= 1'b0;
      r_addr_valid <= 1'b0;
      r_rd_req     <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_reg_wr_en  <= 1'b0;
    end else begin
      r_cmd        <= w_cmd_nxt;
      r_addr       <= w_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_reg_addr   <= w_reg_addr_nxt;
      r_rx_len     <= w_rx_len_nxt;
      r_tx_len     <= w_tx_len_nxt;
      r_err_flag   <= w_err_nxt;
      r_tx_pend    <= w_tx_pend_nxt;
      r_rx_len_upd <= w_rx_len_upd_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_addr_valid <= w_addr_valid_nxt;
      r_rd_req     <= w_rd_req_nxt;
      r_wr_valid   <= w_wr_valid_nxt;
      r_reg_wr_en  <= w_reg_wr_en_nxt;
    end
  end

  assign cmd        = r_cmd;
  assign addr       = r_addr;
  assign wr_data    = r_wr_data;
  assign reg_addr   = r_reg_addr;
  assign rx_len     = r_rx_len;
  assign tx_len     = r_tx_len;
  assign err_flag   = r_err_flag;
  assign rx_len_upd = r_rx_len_upd;
  assign tx_start   = r_tx_start;
  assign addr_valid = r_addr_valid;
  assign rd_req     = r_rd_req;
  assign wr_valid   = r_wr_valid;
  assign reg_wr_en  = r_reg_wr_en;

endmodule

// File: tb/tb_spi_slave_ctrl_fsm.sv
// Bench for spi_slave_ctrl_fsm: behavioural command decoder, strobe scoreboard with cycle stamps,
// a table of register commands and hand-written memory burst / abort / reset sequences.
module tb_spi_slave_ctrl_fsm;
  import spi_slave_pkg::*;

  logic        sclk = 1'b0;
  logic        rst, cs_n, rx_valid, tx_done;
  logic [31:0] rx_data;
  logic [7:0]  dummy_cycles;
  logic [7:0]  cmd;
  logic        get_addr, get_data, send_data, enable_cont, enable_regs, wait_dummy, error;
  logic [1:0]  reg_sel;
  logic [5:0]  rx_len, tx_len;
  logic        rx_len_upd, tx_start, addr_valid, rd_req, wr_valid, reg_wr_en, err_flag;
  logic [31:0] addr, wr_data;
  logic [1:0]  reg_addr;

  spi_slave_ctrl_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
    .sclk(sclk), .rst(rst), .cs_n(cs_n), .rx_valid(rx_valid), .rx_data(rx_data), .cmd(cmd),
    .get_addr(get_addr), .get_data(get_data), .send_data(send_data),
    .enable_cont(enable_cont), .enable_regs(enable_regs), .wait_dummy(wait_dummy),
    .error(error), .reg_sel(reg_sel), .dummy_cycles(dummy_cycles),
    .rx_len(rx_len), .rx_len_upd(rx_len_upd), .tx_len(tx_len), .tx_start(tx_start),
    .tx_done(tx_done), .addr(addr), .addr_valid(addr_valid), .rd_req(rd_req),
    .wr_data(wr_data), .wr_valid(wr_valid), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .err_flag(err_flag)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // Decoder model driven from the latched command.
  always_comb begin
    get_addr = 1'b0; get_data = 1'b0; send_data = 1'b0; enable_cont = 1'b0;
    enable_regs = 1'b0; wait_dummy = 1'b0; error = 1'b0; reg_sel = 2'd0;
    case (cmd)
      CMD_WR_REG0:    begin get_data = 1'b1; enable_regs = 1'b1; end
      CMD_WR_REG1:    begin get_data = 1'b1; enable_regs = 1'b1; reg_sel = 2'd1; end
      CMD_RD_REG0:    begin send_data = 1'b1; enable_regs = 1'b1; end
      CMD_RD_REG1:    begin send_data = 1'b1; enable_regs = 1'b1; reg_sel = 2'd1; end
      CMD_WR_MEM:     begin get_addr = 1'b1; get_data = 1'b1; enable_cont = 1'b1; end
      CMD_RD_MEM_FST: begin get_addr = 1'b1; wait_dummy = 1'b1; send_data = 1'b1; enable_cont = 1'b1; end
      default:        error = 1'b1;
    endcase
  end

  localparam int EV_RXUPD = 0, EV_AVLD = 1, EV_RD = 2, EV_TXS = 3, EV_WR = 4, EV_REGWR = 5;
  typedef struct {int kind; logic [31:0] val; logic [31:0] aux; int cyc;} ev_t;
  ev_t exp_q[$];
  int  n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at cycle %0d", name, got, exp, cyc);
  endtask

  task automatic push(input int kind, input logic [31:0] val, input logic [31:0] aux, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.aux = aux; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] val, input logic [31:0] aux);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_unexpected: kind %0d val 0x%08h aux 0x%08h at cycle %0d, required none",
               kind, val, aux, cyc);
    end else begin
      e = exp_q.pop_front();
      if (kind == e.kind && val === e.val && aux === e.aux && cyc == e.cyc) n_pass++;
      else $display("FAIL sb_event: got kind %0d val 0x%08h aux 0x%08h cyc %0d, required kind %0d val 0x%08h aux 0x%08h cyc %0d",
                    kind, val, aux, cyc, e.kind, e.val, e.aux, e.cyc);
    end
  endtask

  // Strobe monitor, sampled mid-cycle; same-cycle strobes are taken in a fixed order.
  always @(negedge sclk) begin
    if (rx_len_upd) sb_pop(EV_RXUPD, 32'(rx_len), 32'd0);
    if (addr_valid) sb_pop(EV_AVLD, addr, 32'd0);
    if (rd_req)     sb_pop(EV_RD, addr, 32'd0);
    if (tx_start)   sb_pop(EV_TXS, 32'(tx_len), 32'd0);
    if (wr_valid)   sb_pop(EV_WR, wr_data, addr);
    if (reg_wr_en)  sb_pop(EV_REGWR, 32'(wr_data[7:0]), 32'(reg_addr));
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    chk({tag, "_rx_len"}, 32'(rx_len), 32'd8);
    chk({tag, "_tx_len"}, 32'(tx_len), 32'd8);
    chk({tag, "_strobes"}, 32'({rx_len_upd, tx_start, addr_valid, rd_req, wr_valid, reg_wr_en}), 32'd0);
    chk({tag, "_err_flag"}, 32'(err_flag), 32'd0);
  endtask

  task automatic send_cmd(input logic [7:0] op, input int kind, input logic [31:0] val);
    int c;
    c = cyc; rx_valid = 1'b1; rx_data = 32'(op);
    if (kind >= 0) push(kind, val, 32'd0, c + 2);
    tick(); rx_valid = 1'b0;
    chk("cmd_latch", 32'(cmd), 32'(op));
    tick();
  endtask

  task automatic abort_cs();
    int e;
    e = cyc; cs_n = 1'b1; push(EV_RXUPD, 32'd8, 32'd0, e + 1);
    tick(); rx_valid = 1'b0; tx_done = 1'b0;
    chk("abort_err_clr", 32'(err_flag), 32'd0);
    chk("abort_rx_len", 32'(rx_len), 32'd8);
    tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {logic [7:0] op; logic [7:0] dat; bit wr; bit err; logic [1:0] ra;} vec_t;

  task automatic run_vec(input vec_t v);
    int d;
    cs_n = 1'b0; tick();
    if (v.err)     send_cmd(v.op, -1, 32'd0);
    else if (v.wr) send_cmd(v.op, EV_RXUPD, 32'd8);
    else           send_cmd(v.op, EV_TXS, 32'd8);
    if (v.err) begin
      chk("err_set", 32'(err_flag), 32'd1);
      rx_valid = 1'b1; tx_done = 1'b1; rx_data = 32'hDEAD_BEEF;
      tick(); rx_valid = 1'b0; tx_done = 1'b0; tick();
      chk("err_held", 32'(err_flag), 32'd1);
    end else if (v.wr) begin
      chk("reg_rx_len", 32'(rx_len), 32'd8);
      d = cyc; rx_valid = 1'b1; rx_data = 32'(v.dat);
      push(EV_REGWR, 32'(v.dat), 32'(v.ra), d + 1);
      tick(); rx_valid = 1'b0;
      chk("reg_wr_addr", 32'(reg_addr), 32'(v.ra));
      chk("reg_wr_data", 32'(wr_data[7:0]), 32'(v.dat));
      rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    end else begin
      chk("reg_tx_len", 32'(tx_len), 32'd8);
      chk("reg_rd_addr", 32'(reg_addr), 32'(v.ra));
      tick(); tx_done = 1'b1; tick(); tx_done = 1'b0;
      tx_done = 1'b1; tick(); tx_done = 1'b0;
    end
    abort_cs();
  endtask

  task automatic mem_write();
    int a, w, e;
    cs_n = 1'b0; tick();
    send_cmd(CMD_WR_MEM, EV_RXUPD, 32'd32);
    a = cyc; rx_valid = 1'b1; rx_data = 32'h0000_1000;
    push(EV_RXUPD, 32'd32, 32'd0, a + 1);
    push(EV_AVLD, 32'h0000_1000, 32'd0, a + 1);
    tick(); rx_valid = 1'b0;
    w = cyc; rx_valid = 1'b1; rx_data = 32'h1111_1111;
    push(EV_WR, 32'h1111_1111, 32'h0000_1000, w + 1);
    tick(); rx_valid = 1'b0; tick();
    chk("wr_addr_inc1", addr, 32'h0000_1004);
    w = cyc; rx_valid = 1'b1; rx_data = 32'h2222_2222;
    push(EV_WR, 32'h2222_2222, 32'h0000_1004, w + 1);
    tick(); rx_valid = 1'b0; tick(); tick();
    chk("wr_addr_inc2", addr, 32'h0000_1008);
    e = cyc; rx_valid = 1'b1; rx_data = 32'h3333_3333; cs_n = 1'b1;
    push(EV_RXUPD, 32'd8, 32'd0, e + 1);
    tick(); rx_valid = 1'b0;
    chk("abort_rx_wr_data", wr_data, 32'h2222_2222);
    tick();
    chk("abort_addr_kept", addr, 32'h0000_1008);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic mem_read(input int d);
    int a, t;
    dummy_cycles = 8'(d); cs_n = 1'b0; tick();
    send_cmd(CMD_RD_MEM_FST, EV_RXUPD, 32'd32);
    a = cyc; rx_valid = 1'b1; rx_data = 32'hFFFF_FFFC;
    push(EV_AVLD, 32'hFFFF_FFFC, 32'd0, a + 1);
    push(EV_RD, 32'hFFFF_FFFC, 32'd0, a + 1);
    push(EV_TXS, 32'd32, 32'd0, a + 2 + d);
    tick(); rx_valid = 1'b0;
    repeat (d + 2) tick();
    t = cyc; tx_done = 1'b1;
    push(EV_RD, 32'h0000_0000, 32'd0, t + 1);
    push(EV_TXS, 32'd32, 32'd0, t + 2);
    tick(); tx_done = 1'b0;
    chk("rd_addr_wrap", addr, 32'h0000_0000);
    tick();
    abort_cs();
    chk("rd_addr_kept", addr, 32'h0000_0000);
  endtask

  task automatic reset_in_dummy();
    cs_n = 1'b0; dummy_cycles = 8'd5; tick();
    send_cmd(CMD_RD_MEM_FST, EV_RXUPD, 32'd32);
    rx_valid = 1'b1; rx_data = 32'h0000_0080;
    push(EV_AVLD, 32'h0000_0080, 32'd0, cyc + 1);
    push(EV_RD, 32'h0000_0080, 32'd0, cyc + 1);
    tick(); rx_valid = 1'b0; tick();
    rst = 1'b1; tick();
    check_reset("rst_dummy");
    rst = 1'b0; cs_n = 1'b1;
    repeat (8) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vt[5];
    vt[0] = '{op: CMD_WR_REG0, dat: 8'hA5, wr: 1'b1, err: 1'b0, ra: 2'd0};
    vt[1] = '{op: CMD_WR_REG1, dat: 8'h5A, wr: 1'b1, err: 1'b0, ra: 2'd1};
    vt[2] = '{op: CMD_RD_REG0, dat: 8'h00, wr: 1'b0, err: 1'b0, ra: 2'd0};
    vt[3] = '{op: CMD_RD_REG1, dat: 8'h00, wr: 1'b0, err: 1'b0, ra: 2'd1};
    vt[4] = '{op: 8'h3C,       dat: 8'h00, wr: 1'b0, err: 1'b1, ra: 2'd0};

    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 32'd0; tx_done = 1'b0; dummy_cycles = 8'd0;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0; tick();

    for (int i = 0; i < 5; i++) run_vec(vt[i]);
    chk("reg_cmds_addr_untouched", addr, 32'd0);

    mem_write();
    mem_read(0);
    mem_read(3);
    reset_in_dummy();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
